// File: rtl/adain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adain_pkg
// Purpose  : Shared fixed-point constants, accumulator-width helpers and the
//            FSM state type for the AdaIN channel-statistics stage.
//            Input pixels are signed Q8.8. Outputs are signed Q12.20.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package adain_pkg;

  localparam int          c_DATA_W     = 16;                        // Q8.8 pixel
  localparam int          c_FRAC_IN    = 8;
  localparam int          c_OUT_W      = 32;                        // Q12.20 result
  localparam int          c_FRAC_OUT   = 20;
  localparam int          c_LOG2_N     = 10;                        // 1024 pixels
  localparam int          c_MEAN_SHIFT = c_FRAC_OUT - c_FRAC_IN;     // Q8.8   -> Q12.20
  localparam int          c_VAR_SHIFT  = c_FRAC_OUT - 2 * c_FRAC_IN; // Q16.16 -> Q12.20
  localparam logic [31:0] c_EPS        = 32'd10;                    // ~1e-5 in Q12.20

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    MEAN = 2'd1,
    VAR  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Signed running sum of 2**log2_n pixels.
  function automatic int sum_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

  // Unsigned running sum of 2**log2_n squared pixels.
  function automatic int sumsq_width(input int data_w, input int log2_n);
    return 2 * data_w + log2_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adain_square.sv
`default_nettype none
// ============================================================================
// Module   : adain_square
// Purpose  : Combinational signed squarer. The square of a two's-complement
//            value is never negative, so the result is returned unsigned at
//            full 2*DATA_W width (covers (-2**(DATA_W-1))**2 exactly).
// Ports    : a  - signed DATA_W operand
//            sq - unsigned 2*DATA_W square
// Revision : 1.0 - initial release
// ============================================================================
module adain_square #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   a,
  output logic        [2*DATA_W-1:0] sq
);

  logic signed [2*DATA_W-1:0] w_ext;

  assign w_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign sq    = $unsigned(w_ext * w_ext);

endmodule
`default_nettype wire

// File: rtl/adain_stats_accum.sv
`default_nettype none
// ============================================================================
// Module   : adain_stats_accum
// Purpose  : Accumulates one channel of 2**LOG2_N signed Q8.8 pixels and
//            produces the channel mean and (variance + EPS) in signed Q12.20.
//            The variance output feeds the inverse-square-root unit.
// Config   : `define ADAIN_VAR_SAT_EN saturates out_var at the largest
//            positive OUT_W value; otherwise out_var keeps the low OUT_W bits.
// Ports    : clk, rst_n (async, active-low)
//            in_data/in_valid/in_ready    - pixel stream
//            out_mean/out_var/out_valid/out_ready - per-channel results
// Revision : 1.0 - initial release
// ============================================================================
module adain_stats_accum
  import adain_pkg::*;
#(
  parameter int          DATA_W = c_DATA_W,
  parameter int          LOG2_N = c_LOG2_N,
  parameter int          OUT_W  = c_OUT_W,
  parameter logic [31:0] EPS    = c_EPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic        [OUT_W-1:0]  out_mean,
  output logic        [OUT_W-1:0]  out_var,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int                c_SUM_W   = sum_width(DATA_W, LOG2_N);
  localparam int                c_SUMSQ_W = sumsq_width(DATA_W, LOG2_N);
  localparam int                c_SQ_W    = 2 * DATA_W;
  localparam int                c_V_W     = c_SQ_W + c_VAR_SHIFT + 1;
  localparam logic [LOG2_N-1:0] c_CNT_LAST = '1;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [LOG2_N-1:0]          r_cnt;
  logic signed [c_SUM_W-1:0]  r_sum;
  logic [c_SUMSQ_W-1:0]       r_sumsq;
  logic signed [DATA_W-1:0]   r_mean_q;
  logic [c_SQ_W-1:0]          r_avg_sq;
  logic [OUT_W-1:0]           r_out_mean;
  logic [OUT_W-1:0]           r_out_var;

  logic                       w_in_hs;
  logic signed [DATA_W-1:0]   w_sq_operand;
  logic [c_SQ_W-1:0]          w_sq;
  logic [c_SQ_W-1:0]          w_d;
  logic [c_V_W-1:0]           w_v;
  logic [OUT_W-1:0]           w_var_out;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && (r_cnt == c_CNT_LAST)) w_state_nxt = MEAN;
      end
      MEAN: w_state_nxt = VAR;
      VAR:  w_state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ACC;
      end
      default: w_state_nxt = ACC;
    endcase
  end

  assign w_in_hs = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // Shared squarer: pixels while accumulating, the mean in VAR. The two uses
  // never overlap because in_ready is low outside ACC.
  // --------------------------------------------------------------------------
  assign w_sq_operand = (r_state == VAR) ? r_mean_q : in_data;

  adain_square #(
    .DATA_W (DATA_W)
  ) u_square (
    .a  (w_sq_operand),
    .sq (w_sq)
  );

  // E[x^2] - floor(mean)^2 can dip below zero from the floor in both terms.
  assign w_d = (r_avg_sq > w_sq) ? (r_avg_sq - w_sq) : '0;
  assign w_v = (c_V_W'(w_d) << c_VAR_SHIFT) + c_V_W'(EPS);

`ifdef ADAIN_VAR_SAT_EN
  localparam logic [c_V_W-1:0] c_VAR_MAX =
    {{(c_V_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign w_var_out = (w_v > c_VAR_MAX) ? {1'b0, {(OUT_W-1){1'b1}}} : OUT_W'(w_v);
`else
  // Upstream range analysis keeps the variance far below the wrap point.
  assign w_var_out = OUT_W'(w_v);
`endif

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_sum      <= '0;
      r_sumsq    <= '0;
      r_mean_q   <= '0;
      r_avg_sq   <= '0;
      r_out_mean <= '0;
      r_out_var  <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_in_hs) begin
            r_sum   <= r_sum + c_SUM_W'(in_data);
            r_sumsq <= r_sumsq + c_SUMSQ_W'(w_sq);
            r_cnt   <= r_cnt + 1'b1;   // wraps to 0 on the last pixel
          end
        end
        MEAN: begin
          // Taking the top bits is a floor division by N for both sums.
          r_mean_q <= r_sum[c_SUM_W-1 -: DATA_W];
          r_avg_sq <= r_sumsq[c_SUMSQ_W-1 -: c_SQ_W];
        end
        VAR: begin
          r_out_var  <= w_var_out;
          r_out_mean <= {{(OUT_W-DATA_W-c_MEAN_SHIFT){r_mean_q[DATA_W-1]}},
                         r_mean_q, {c_MEAN_SHIFT{1'b0}}};
        end
        OUT: begin
          if (out_ready) begin
            r_sum   <= '0;
            r_sumsq <= '0;
            r_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_mean = r_out_mean;
  assign out_var  = r_out_var;

endmodule
`default_nettype wire

// File: tb/tb_adain_stats_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_adain_stats_accum
// Purpose  : Self-checking bench. A small instance (4 pixels/channel) runs
//            directed and random channels; a full-size instance (1024
//            pixels/channel) runs random channels. Expected results come from
//            an arithmetic reference model and are queued per instance; a
//            monitor compares whatever each instance presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adain_stats_accum;

  localparam int DW   = 16;
  localparam int OW   = 32;
  localparam int LG_A = 2;
  localparam int LG_B = 10;

  typedef struct {
    logic [31:0] mean;
    logic [31:0] var_v;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 sel = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 bp_hold = 1'b0;

  logic                 in_valid_a, in_valid_b, in_ready_a, in_ready_b, in_ready_mux;
  logic                 out_valid_a, out_valid_b;
  logic [OW-1:0]        out_mean_a, out_var_a, out_mean_b, out_var_b;

  assign in_valid_a   = in_valid & ~sel;
  assign in_valid_b   = in_valid & sel;
  assign in_ready_mux = sel ? in_ready_b : in_ready_a;

  adain_stats_accum #(.DATA_W(DW), .LOG2_N(LG_A), .OUT_W(OW), .EPS(32'd10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .out_mean(out_mean_a), .out_var(out_var_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  adain_stats_accum #(.DATA_W(DW), .LOG2_N(LG_B), .OUT_W(OW), .EPS(32'd10)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .out_mean(out_mean_b), .out_var(out_var_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_hs_cyc  = -100;
  int   first_hs_cyc = 0;
  int   out_hs_cyc_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: floor mean, floor E[x^2], clamp, scale to Q12.20, add eps.
  function automatic exp_t model(input int s[$], input int lg);
    longint n, sum, sumsq, m, d, v;
    exp_t   e;
    n = longint'(1) << lg;
    sum = 0;
    sumsq = 0;
    foreach (s[i]) begin
      sum   += s[i];
      sumsq += longint'(s[i]) * s[i];
    end
    m = sum / n;
    if ((sum % n != 0) && (sum < 0)) m -= 1;
    d = sumsq / n - m * m;
    if (d < 0) d = 0;
    v = d * 16 + 10;
    e.mean = 32'(m * 4096);
`ifdef ADAIN_VAR_SAT_EN
    e.var_v = (v > 64'sd2147483647) ? 32'h7FFFFFFF : 32'(v);
`else
    e.var_v = 32'(v);
`endif
    return e;
  endfunction

  function automatic int rnd_sample(input int lim);
    if (lim == 0) return int'(shortint'($urandom));
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  // Out-ready driver: random acceptance unless a hold is requested.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitors: every cycle a result is presented it must match the head of
  // the queue; the head is retired on the output handshake.
  logic prev_va = 1'b0, prev_vb = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_a && !prev_va) check("latency_a", 64'(cyc), 64'(last_hs_cyc + 2));
      if (out_valid_a) begin
        if (sb_a.size() == 0) check("unexpected_out_a", 64'd1, 64'd0);
        else begin
          check("mean_a", 64'(out_mean_a), 64'(sb_a[0].mean));
          check("var_a", 64'(out_var_a), 64'(sb_a[0].var_v));
          check("in_ready_in_out_a", 64'(in_ready_a), 64'd0);
          if (out_ready) begin
            void'(sb_a.pop_front());
            out_hs_cyc_a = cyc + 1;
          end
        end
      end
      if (out_valid_b && !prev_vb) check("latency_b", 64'(cyc), 64'(last_hs_cyc + 2));
      if (out_valid_b) begin
        if (sb_b.size() == 0) check("unexpected_out_b", 64'd1, 64'd0);
        else begin
          check("mean_b", 64'(out_mean_b), 64'(sb_b[0].mean));
          check("var_b", 64'(out_var_b), 64'(sb_b[0].var_v));
          if (out_ready) void'(sb_b.pop_front());
        end
      end
    end
    prev_va = out_valid_a;
    prev_vb = out_valid_b;
  end

  // Called at posedge+1; returns at posedge+1 after the last handshake.
  task automatic send(input int s[$], input int max_gap);
    int g;
    bit hs;
    foreach (s[k]) begin
      g = (max_gap > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, max_gap)) : 0;
      in_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      in_data  = DW'(s[k]);
      in_valid = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 200 && !hs; t++) begin
        @(negedge clk);
        hs = in_ready_mux;
        @(posedge clk);
        #1;
      end
      if (!hs) check("input_handshake_timeout", 64'd0, 64'd1);
      if (k == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_channel(input int s[$], input int max_gap);
    send(s, max_gap);
    if (!sel) sb_a.push_back(model(s, LG_A));
    else      sb_b.push_back(model(s, LG_B));
  endtask

  task automatic send_expect(input int s[$], input logic [31:0] m, input logic [31:0] v);
    exp_t e;
    send(s, 0);
    e.mean  = m;
    e.var_v = v;
    sb_a.push_back(e);
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && (sb_a.size() != 0 || sb_b.size() != 0); t++) @(posedge clk);
    check("drain_pending", 64'(sb_a.size() + sb_b.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200_000_0;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s[$];
    int q[$];

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("rst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_out_mean_a", 64'(out_mean_a), 64'd0);
    check("rst_out_var_a", 64'(out_var_a), 64'd0);
    check("rst_in_ready_b", 64'(in_ready_b), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed channels with literal expected values
    send_expect('{16'h0100, 16'h0200, 16'h0300, 16'h0400}, 32'h00280000, 32'h0014000A);
    send_expect('{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 32'h00100000, 32'h0000000A);
    send_expect('{-256, -256, -256, -256}, 32'hFFF00000, 32'h0000000A);
`ifdef ADAIN_VAR_SAT_EN
    send_expect('{16'h7F00, -32768, 16'h7F00, -32768}, 32'hFFF80000, 32'h7FFFFFFF);
`else
    send_expect('{16'h7F00, -32768, 16'h7F00, -32768}, 32'hFFF80000, 32'hF804000A);
`endif

    // Backpressure: results held, input blocked, then prompt re-acceptance
    send_expect('{16'h0100, 16'h0200, 16'h0300, 16'h0400}, 32'h00280000, 32'h0014000A);
    bp_hold  = 1'b1;
    in_data  = 16'h0100;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !out_valid_a; t++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid_a), 64'd1);
      check("bp_in_ready", 64'(in_ready_a), 64'd0);
    end
    @(posedge clk);
    #1;
    bp_hold = 1'b0;
    send_expect('{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 32'h00100000, 32'h0000000A);
    check("accept_after_out_hs", 64'(first_hs_cyc), 64'(out_hs_cyc_a + 1));
    drain();

    // Mid-channel reset discards the partial channel
    send('{16'h0700, 16'h0900}, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready_a), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_expect('{16'h0100, 16'h0200, 16'h0300, 16'h0400}, 32'h00280000, 32'h0014000A);

    // Random small channels against the model
    for (int c = 0; c < 20; c++) begin
      s = {};
      for (int i = 0; i < (1 << LG_A); i++) s.push_back(rnd_sample((c % 2 == 0) ? 0 : 300));
      run_channel(s, 3);
    end
    drain();

    // Full-size channels: full-range and narrow-range pixels
    sel = 1'b1;
    for (int c = 0; c < 2; c++) begin
      q = {};
      for (int i = 0; i < (1 << LG_B); i++) q.push_back(rnd_sample((c == 0) ? 0 : 2048));
      run_channel(q, 3);
    end
    drain();
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
